// File: rtl/cnt_share_ctrl.sv
// rtl/cnt_share_ctrl.sv - round-robin sequencer time-sharing one start/stop counter
//
// Purpose:
//   Arbitrates NREQ requesters round-robin for a single shared up-counter.
//   For each winner it clears the counter, starts it, watches cnt_val until
//   the winner's sampled target is reached (or the winner drops its request),
//   then stops the counter and reports completion with a one-cycle done pulse.
//
// Ports:
//   clk        clock
//   reset      asynchronous, active-high reset
//   req        per-requester level request, held until done for that requester
//   tgt        packed targets, requester i at [i*CW +: CW], sampled at grant
//   gnt        one-hot grant, held for the whole run
//   busy       high whenever the sequencer is not idle
//   done       one-cycle completion pulse
//   done_id    index of the completed requester (valid with done)
//   done_cnt   final counter value (valid with done)
//   abort      with done: run was cut short because the request dropped
//   cnt_clr    counter clear pulse
//   cnt_start  counter start pulse
//   cnt_stop   counter stop pulse
//   cnt_val    current counter value

module cnt_share_ctrl #(
  parameter int NREQ = 4,
  parameter int CW   = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*CW-1:0]   tgt,
  output logic [NREQ-1:0]      gnt,
  output logic                 busy,
  output logic                 done,
  output logic [IDW-1:0]       done_id,
  output logic [CW-1:0]        done_cnt,
  output logic                 abort,
  output logic                 cnt_clr,
  output logic                 cnt_start,
  output logic                 cnt_stop,
  input  logic [CW-1:0]        cnt_val
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  rr_ptr_n;
  logic [IDW-1:0]  gnt_id;
  logic [IDW-1:0]  gnt_id_n;
  logic [CW-1:0]   tgt_q;
  logic [CW-1:0]   tgt_q_n;

  logic [NREQ-1:0] gnt_n;
  logic            busy_n;
  logic            done_n;
  logic [IDW-1:0]  done_id_n;
  logic [CW-1:0]   done_cnt_n;
  logic            abort_n;
  logic            cnt_clr_n;
  logic            cnt_start_n;
  logic            cnt_stop_n;

  logic [IDW:0]    rr_sum;
  logic [IDW-1:0]  rr_idx;
  logic            rr_found;
  logic [IDW-1:0]  rr_pick;
  logic [IDW:0]    rr_next;
  logic [CW-1:0]   pick_tgt;

  // Round-robin search: first set request at or above rr_ptr, wrapping at
  // NREQ. The sum is one bit wider so the wrap works for non-power-of-two NREQ.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = '0;
    rr_sum   = '0;
    rr_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      rr_sum = {1'b0, rr_ptr} + (IDW+1)'(i);
      if (rr_sum >= (IDW+1)'(NREQ)) begin
        rr_sum = rr_sum - (IDW+1)'(NREQ);
      end
      rr_idx = rr_sum[IDW-1:0];
      if (!rr_found && req[rr_idx]) begin
        rr_found = 1'b1;
        rr_pick  = rr_idx;
      end
    end
  end

  // Pointer advance past the winner, and the winner's target slice.
  always_comb begin
    rr_next = {1'b0, rr_pick} + (IDW+1)'(1);
    if (rr_next == (IDW+1)'(NREQ)) begin
      rr_next = '0;
    end
    pick_tgt = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (rr_pick == IDW'(i)) begin
        pick_tgt = tgt[i*CW +: CW];
      end
    end
  end

  // Next-state logic. Every output is registered from a value computed here,
  // so nothing on req or cnt_val reaches an output combinationally.
  always_comb begin
    state_n     = state;
    rr_ptr_n    = rr_ptr;
    gnt_id_n    = gnt_id;
    tgt_q_n     = tgt_q;
    gnt_n       = gnt;
    done_cnt_n  = '0;
    abort_n     = 1'b0;
    cnt_start_n = 1'b0;

    case (state)
      IDLE: begin
        if (rr_found) begin
          state_n  = CLEAR;
          gnt_id_n = rr_pick;
          gnt_n    = NREQ'(1) << rr_pick;
          tgt_q_n  = pick_tgt;
          rr_ptr_n = rr_next[IDW-1:0];
        end
      end
      CLEAR: begin
        // A zero target is already satisfied by the clear itself.
        if (tgt_q == '0) begin
          state_n = STOP;
        end else begin
          state_n     = RUN;
          cnt_start_n = 1'b1;
        end
      end
      RUN: begin
        // Match takes priority over a request drop in the same cycle.
        if (cnt_val == tgt_q) begin
          state_n    = STOP;
          done_cnt_n = cnt_val;
        end else if (!req[gnt_id]) begin
          state_n    = STOP;
          done_cnt_n = cnt_val;
          abort_n    = 1'b1;
        end
      end
      STOP: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase

    cnt_clr_n  = (state_n == CLEAR);
    cnt_stop_n = (state_n == STOP);
    done_n     = (state_n == STOP);
    done_id_n  = (state_n == STOP) ? gnt_id_n : '0;
    busy_n     = (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gnt_id    <= '0;
      tgt_q     <= '0;
      gnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      done_id   <= '0;
      done_cnt  <= '0;
      abort     <= 1'b0;
      cnt_clr   <= 1'b0;
      cnt_start <= 1'b0;
      cnt_stop  <= 1'b0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_ptr_n;
      gnt_id    <= gnt_id_n;
      tgt_q     <= tgt_q_n;
      gnt       <= gnt_n;
      busy      <= busy_n;
      done      <= done_n;
      done_id   <= done_id_n;
      done_cnt  <= done_cnt_n;
      abort     <= abort_n;
      cnt_clr   <= cnt_clr_n;
      cnt_start <= cnt_start_n;
      cnt_stop  <= cnt_stop_n;
    end
  end

endmodule

// File: tb/tb_cnt_share_ctrl.sv
// tb/tb_cnt_share_ctrl.sv - self-checking bench for cnt_share_ctrl
module tb_cnt_share_ctrl;

  localparam int NREQ = 4;
  localparam int CW   = 4;
  localparam int IDW  = 2;
  localparam int TMAX = (1 << CW) - 1;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ*CW-1:0]  tgt = '0;
  logic [NREQ-1:0]     gnt;
  logic                busy;
  logic                done;
  logic [IDW-1:0]      done_id;
  logic [CW-1:0]       done_cnt;
  logic                abort;
  logic                cnt_clr;
  logic                cnt_start;
  logic                cnt_stop;
  logic [CW-1:0]       cnt_val;
  logic                run_q;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [NREQ-1:0]    req;
    logic [NREQ*CW-1:0] tgt;
    int                 id;
    int                 cnt;
    int                 lat;
  } vec_t;

  vec_t vecs[7];

  int  m_ptr, w, j, a_id, a_tgt, g_cyc, exp_done, exp_cnt, drop_cyc, r, d, earliest;
  bit  active, exp_abort, ok, got;

  always #5 clk = ~clk;

  cnt_share_ctrl #(.NREQ(NREQ), .CW(CW), .IDW(IDW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .tgt       (tgt),
    .gnt       (gnt),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id),
    .done_cnt  (done_cnt),
    .abort     (abort),
    .cnt_clr   (cnt_clr),
    .cnt_start (cnt_start),
    .cnt_stop  (cnt_stop),
    .cnt_val   (cnt_val)
  );

  // Shared counter: async clear, starts counting the cycle after start.
  always @(posedge clk or posedge reset or posedge cnt_clr) begin
    if (reset || cnt_clr) begin
      cnt_val <= '0;
      run_q   <= 1'b0;
    end else begin
      if (run_q) cnt_val <= cnt_val + 1'b1;
      if (cnt_stop) run_q <= 1'b0;
      else if (cnt_start) run_q <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] oh(input int i);
    oh = NREQ'(1) << i;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"},       32'(gnt),       32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_done"},      32'(done),      32'd0);
    chk({tag, "_done_id"},   32'(done_id),   32'd0);
    chk({tag, "_done_cnt"},  32'(done_cnt),  32'd0);
    chk({tag, "_abort"},     32'(abort),     32'd0);
    chk({tag, "_cnt_clr"},   32'(cnt_clr),   32'd0);
    chk({tag, "_cnt_start"}, 32'(cnt_start), 32'd0);
    chk({tag, "_cnt_stop"},  32'(cnt_stop),  32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    tgt   = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_done(output bit okv);
    okv = 1'b0;
    for (int k = 0; k < 40 && !okv; k++) begin
      @(negedge clk);
      chk("gnt_onehot", 32'($onehot(gnt)), 32'd1);
      if (done) okv = 1'b1;
    end
  endtask

  task automatic wait_cnt(input logic [CW-1:0] v, output bit okv);
    okv = 1'b0;
    for (int k = 0; k < 40 && !okv; k++) begin
      @(negedge clk);
      if (busy && !done && cnt_val == v) okv = 1'b1;
    end
  endtask

  task automatic wait_gnt(output bit okv);
    okv = 1'b0;
    for (int k = 0; k < 40 && !okv; k++) begin
      @(negedge clk);
      if (gnt != '0) okv = 1'b1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // {req, tgt, winner, done_cnt, cycles from request to done}
    vecs[0] = '{4'b0001, 16'h0005, 0, 5,  9};
    vecs[1] = '{4'b0100, 16'h0000, 2, 0,  2};
    vecs[2] = '{4'b1111, 16'h4321, 3, 4,  8};
    vecs[3] = '{4'b1010, 16'h4321, 1, 2,  6};
    vecs[4] = '{4'b0011, 16'h00F1, 0, 1,  5};
    vecs[5] = '{4'b1000, 16'hF000, 3, 15, 19};
    vecs[6] = '{4'b0010, 16'h0070, 1, 7,  11};

    #1;
    reset = 1'b1;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Table-driven single transactions.
    foreach (vecs[v]) begin
      @(negedge clk);
      req = vecs[v].req;
      tgt = vecs[v].tgt;
      got = 1'b0;
      for (int k = 1; k <= 40 && !got; k++) begin
        @(negedge clk);
        if (k == 1) begin
          chk("tbl_gnt", 32'(gnt), 32'(oh(vecs[v].id)));
          chk("tbl_clr", 32'(cnt_clr), 32'd1);
        end
        if (k == 2) chk("tbl_start", 32'(cnt_start), 32'(vecs[v].cnt != 0));
        if (done) begin
          got = 1'b1;
          chk("tbl_latency", 32'(k), 32'(vecs[v].lat));
          chk("tbl_done_id", 32'(done_id), 32'(vecs[v].id));
          chk("tbl_done_cnt", 32'(done_cnt), 32'(vecs[v].cnt));
          chk("tbl_abort", 32'(abort), 32'd0);
          chk("tbl_stop", 32'(cnt_stop), 32'd1);
          req = '0;
        end
      end
      chk("tbl_done_seen", 32'(got), 32'd1);
      req = '0;
      @(negedge clk);
      chk("tbl_gap_gnt", 32'(gnt), 32'd0);
      chk("tbl_gap_busy", 32'(busy), 32'd0);
    end

    // Abort: requester 1 drops while the counter shows 3.
    @(negedge clk);
    req = 4'b0010; tgt = 16'h00F0;
    wait_cnt(4'd3, ok);
    chk("abort_reach3", 32'(ok), 32'd1);
    req = '0;
    wait_done(ok);
    chk("abort_done", 32'(ok), 32'd1);
    chk("abort_flag", 32'(abort), 32'd1);
    chk("abort_id", 32'(done_id), 32'd1);
    chk("abort_cnt", 32'(done_cnt), 32'd3);
    @(negedge clk);
    req = 4'b0001; tgt = 16'h0002;
    wait_done(ok);
    req = '0;
    chk("after_abort_done", 32'(ok), 32'd1);
    chk("after_abort_flag", 32'(abort), 32'd0);
    chk("after_abort_id", 32'(done_id), 32'd0);
    chk("after_abort_cnt", 32'(done_cnt), 32'd2);

    // Match and drop in the same cycle: the match wins.
    @(negedge clk);
    req = 4'b1000; tgt = 16'h7000;
    wait_cnt(4'd7, ok);
    chk("coll_reach7", 32'(ok), 32'd1);
    req = '0;
    wait_done(ok);
    chk("coll_done", 32'(ok), 32'd1);
    chk("coll_abort", 32'(abort), 32'd0);
    chk("coll_id", 32'(done_id), 32'd3);
    chk("coll_cnt", 32'(done_cnt), 32'd7);

    // Asynchronous reset mid-run, then search restarts from requester 0.
    @(negedge clk);
    req = 4'b0100; tgt = 16'h0900;
    wait_cnt(4'd4, ok);
    chk("rst_reach4", 32'(ok), 32'd1);
    reset = 1'b1;
    #1;
    check_all_zero("midrun_reset");
    req = '0;
    @(negedge clk);
    chk("rst_no_done", 32'(done), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_no_done2", 32'(done), 32'd0);
    req = 4'b1001; tgt = 16'h1002;
    wait_done(ok);
    req = '0;
    chk("rst_next_done", 32'(ok), 32'd1);
    chk("rst_next_id", 32'(done_id), 32'd0);
    chk("rst_next_cnt", 32'(done_cnt), 32'd2);

    // Round-robin with all requests held.
    @(negedge clk);
    do_reset();
    req = 4'b1111; tgt = 16'h2222;
    for (int n = 0; n < 5; n++) begin
      wait_gnt(ok);
      chk("rr_gnt_seen", 32'(ok), 32'd1);
      chk("rr_gnt", 32'(gnt), 32'(oh(n % NREQ)));
      wait_done(ok);
      chk("rr_done", 32'(ok), 32'd1);
      chk("rr_done_id", 32'(done_id), 32'(n % NREQ));
      chk("rr_done_cnt", 32'(done_cnt), 32'd2);
      @(negedge clk);
      chk("rr_gap", 32'(gnt), 32'd0);
    end

    // Randomized traffic against a transaction-level model.
    @(negedge clk);
    do_reset();
    m_ptr = 0; active = 1'b0; earliest = 0; drop_cyc = -1;
    a_id = 0; a_tgt = 0; g_cyc = 0; exp_done = 0; exp_cnt = 0; exp_abort = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (!active) begin
        if (req != '0 && c >= earliest) begin
          w = -1;
          for (int i = 0; i < NREQ; i++) begin
            j = (m_ptr + i) % NREQ;
            if (w < 0 && req[j]) w = j;
          end
          chk("rnd_grant", 32'(gnt), 32'(oh(w)));
          chk("rnd_clr", 32'(cnt_clr), 32'd1);
          chk("rnd_busy", 32'(busy), 32'd1);
          active = 1'b1;
          a_id = w;
          g_cyc = c;
          a_tgt = int'(tgt[w*CW +: CW]);
          m_ptr = (w + 1) % NREQ;
          drop_cyc = -1;
          if (a_tgt == 0) begin
            exp_done = c + 1; exp_cnt = 0; exp_abort = 1'b0;
          end else if ($urandom_range(0, 2) == 0) begin
            r = int'($urandom_range(0, a_tgt + 1));
            d = (r > 0) ? r - 1 : 0;
            drop_cyc = c + 1 + r;
            exp_done = c + 2 + r;
            exp_cnt = d;
            exp_abort = (d != a_tgt);
          end else begin
            exp_done = c + 3 + a_tgt; exp_cnt = a_tgt; exp_abort = 1'b0;
          end
        end else begin
          chk("rnd_idle_gnt", 32'(gnt), 32'd0);
          chk("rnd_idle_busy", 32'(busy), 32'd0);
        end
      end else begin
        chk("rnd_hold_gnt", 32'(gnt), 32'(oh(a_id)));
        chk("rnd_start", 32'(cnt_start), 32'(a_tgt != 0 && c == g_cyc + 1));
        chk("rnd_clr_low", 32'(cnt_clr), 32'd0);
        chk("rnd_done", 32'(done), 32'(c == exp_done));
        if (c == exp_done) begin
          chk("rnd_done_id", 32'(done_id), 32'(a_id));
          chk("rnd_done_cnt", 32'(done_cnt), 32'(exp_cnt));
          chk("rnd_abort", 32'(abort), 32'(exp_abort));
          chk("rnd_stop", 32'(cnt_stop), 32'd1);
          active = 1'b0;
          earliest = c + 2;
          req[a_id] = 1'b0;
        end
      end
      if (active && c == drop_cyc) req[a_id] = 1'b0;
      if (active && $urandom_range(0, 3) == 0) tgt[a_id*CW +: CW] = CW'($urandom_range(0, TMAX));
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && !(active && i == a_id) && $urandom_range(0, 4) == 0) begin
          req[i] = 1'b1;
          tgt[i*CW +: CW] = CW'($urandom_range(0, TMAX));
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cnt_share_ctrl.md
Name: cnt_share_ctrl

Overview:
- Sequences and time-shares one start/stop counter datapath (CW-bit up-counter with start, stop and async-reset inputs, count output) among NREQ requesters.
- Each requester asks for a run to a programmed target count.
- The controller arbitrates round-robin, clears the counter, starts it, and watches its count until the target is hit. It then stops the counter and reports completion to the winner.
- Sits between the requesting sequencers and the shared counter instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- CW, 4, counter width; targets range 0..2^CW-1.
- IDW, 2, requester index width, equal to ceil(log2(NREQ)).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester level request; held until done for that requester.
- tgt  input  NREQ*CW  packed targets; requester i occupies bits [i*CW +: CW]; sampled at grant.
- gnt  output  NREQ  one-hot grant; held for the whole run.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle completion pulse.
- done_id  output  IDW  index of the completed requester; valid with done.
- done_cnt  output  CW  final counter value; valid with done.
- abort  output  1  qualifies done; 1 means the run was cut short because req dropped.
- cnt_clr  output  1  drives the counter reset input; registered, one-cycle pulse.
- cnt_start  output  1  counter start; one-cycle pulse.
- cnt_stop  output  1  counter stop; one-cycle pulse.
- cnt_val  input  CW  counter value.

Behaviour:
- Reset (async) forces:
  - FSM to IDLE and rr_ptr to 0.
  - All outputs to 0, including gnt, done, done_id, done_cnt, abort and the cnt_* pulses.
  - tgt_q to 0.
- All outputs are registered, so there is no combinational path from req or cnt_val to any output.
- FSM states are IDLE, CLEAR, RUN, STOP.
- IDLE:
  - If any req bit is set, grant the first set bit searching upward from rr_ptr with wrap (NREQ-1 wraps to 0).
  - Register gnt, the granted index and tgt_q = that requester's target.
  - Set rr_ptr = granted index + 1 (mod NREQ) and go to CLEAR.
- CLEAR (one cycle):
  - cnt_clr = 1.
  - Next state is RUN with cnt_start = 1 on RUN's first cycle.
  - Exception: if tgt_q == 0, go straight to STOP with no start pulse; done_cnt reports 0.
- RUN:
  - cnt_start is high on the first cycle only.
  - Each cycle, compare cnt_val against tgt_q.
  - On equality, capture done_cnt = cnt_val and go to STOP.
  - If the granted req deasserts, capture done_cnt = cnt_val, set abort, and go to STOP.
  - If the match and the req drop occur in the same cycle, the match wins and abort = 0.
- STOP (one cycle):
  - cnt_stop = 1, done = 1, with done_id, done_cnt and abort valid.
  - gnt clears at the end of this cycle; abort clears with done.
  - Next state is IDLE; a new grant is possible no earlier than the cycle after STOP (minimum 1 idle cycle between runs).
- Latency: req seen in IDLE at cycle N gives:
  - gnt and cnt_clr at N+1;
  - cnt_start at N+2;
  - counter reaches value k at N+3+k;
  - match seen at N+3+tgt, STOP/done at N+4+tgt.
- Wrap: targets are at most 2^CW-1, so the counter never needs to wrap to reach them. If cnt_val passes the target without matching (e.g. an external stall), the controller waits for the next wrap-around equality. No timeout.
- req changes from non-granted requesters during a run are ignored. tgt changes after grant are ignored.
- Reset mid-run: returns to IDLE with no done pulse. The counter is left to the system reset.

Test Plan:
- Single request: req=4'b0001, tgt0=5 → gnt=0001 at N+1, cnt_clr at N+1, cnt_start at N+2, done at N+9 with done_id=0, done_cnt=5, abort=0. cnt_stop is coincident with done.
- Round-robin: req=4'b1111 held, all tgt=2 → grants in order 0,1,2,3,0. Exactly one gnt bit set at any time. At least one idle cycle between a done and the next gnt.
- Zero target: req=4'b0100, tgt2=0 → CLEAR then STOP with no cnt_start pulse; done_id=2, done_cnt=0.
- Abort: req1 with tgt1=15, req1 dropped when cnt_val=3 → done with abort=1, done_id=1, done_cnt=3; next request is served normally.
- Match/drop collision: req3 drops in the same cycle cnt_val equals tgt3=7 → done with abort=0, done_cnt=7.
- Async reset mid-RUN at cnt_val=4 → all outputs 0 immediately, no done pulse, and the next grant searches from requester 0.
